mlp_frame_sequencer: RTL and testbench

//  Upstream feeder for the combinational approximate-MLP classifier core.

---
 rtl/mlp_seq_pkg.sv | 22 ++
 rtl/mlp_settle_timer.sv | 34 +++
 rtl/mlp_frame_sequencer.sv | 169 ++++++++++++++++
 tb/tb_mlp_frame_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_seq_pkg.sv
// Shared constants and types for the approximate-MLP frame sequencer.
//   N_FEAT / FEAT_W / CLS_W : frame geometry and classifier result width
//   INP_W                   : width of the flat classifier input bus
//   CNT_W                   : beat counter width, clog2(N_FEAT)
//   seq_state_e             : sequencer FSM states {LOAD, SETTLE, HOLD}
package mlp_seq_pkg;

    localparam int unsigned N_FEAT = 21;
    localparam int unsigned FEAT_W = 4;
    localparam int unsigned CLS_W  = 2;
    localparam int unsigned INP_W  = N_FEAT * FEAT_W;
    localparam int unsigned CNT_W  = $clog2(N_FEAT);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } seq_state_e;

    typedef logic [CNT_W-1:0] beat_cnt_t;

endpackage

// File: rtl/mlp_settle_timer.sv
// Loadable down-counter that times the classifier settle window.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load CYCLES; the window begins the following cycle
//   done       : high on the last cycle of the window
//   near_done  : high on the cycle before the last (valid for CYCLES >= 2)
module mlp_settle_timer #(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done,
    output logic near_done
);

    localparam int unsigned TW = $clog2(CYCLES + 1);

    logic [TW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (start) begin
            count_q <= TW'(CYCLES);
        end else if (count_q != '0) begin
            count_q <= count_q - TW'(1);
        end
    end

    // Count value N means N window cycles remain, including the current one.
    assign done      = (count_q == TW'(1));
    assign near_done = (count_q == TW'(2));

endmodule

// File: rtl/mlp_frame_sequencer.sv
// Frame collector and result capture for the combinational approximate-MLP core.
// Gathers 21 4-bit feature beats into clf_inp, holds them for SETTLE_CYC cycles,
// captures the argmax class from clf_out and offers it on a valid/ready handshake.
// Optional feature: define MLP_SEQ_STABLE_EN to also sample clf_out one cycle
// early and flag res_err when the two samples disagree.
//   clk, rst_n                         : clock, asynchronous active-low reset
//   feat_valid/feat_data/feat_last     : feature beat stream in
//   feat_ready                         : beat accepted (LOAD only)
//   clf_inp                            : flat feature vector to classifier
//   clf_out                            : classifier argmax result
//   res_valid/res_class/res_ready      : result handshake
//   res_err                            : result unstable (optional feature)
//   frame_err                          : 1-cycle pulse on malformed frame
//   busy                               : SETTLE or HOLD
module mlp_frame_sequencer
    import mlp_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             feat_valid,
    input  logic [FEAT_W-1:0] feat_data,
    input  logic             feat_last,
    output logic             feat_ready,
    output logic [INP_W-1:0] clf_inp,
    input  logic [CLS_W-1:0] clf_out,
    output logic             res_valid,
    output logic [CLS_W-1:0] res_class,
    input  logic             res_ready,
    output logic             res_err,
    output logic             frame_err,
    output logic             busy
);

    seq_state_e       state_q, state_d;
    beat_cnt_t        cnt_q;
    logic [INP_W-1:0] inp_q;
    logic [CLS_W-1:0] res_class_q;
    logic             frame_err_q;

    logic beat_acc;
    logic is_last_slot;
    logic frame_bad;
    logic timer_start;
    logic timer_done;
    logic timer_near;

    assign is_last_slot = (cnt_q == CNT_W'(N_FEAT - 1));
    // A frame is malformed when feat_last disagrees with the slot position.
    assign frame_bad    = beat_acc && (feat_last != is_last_slot);

    mlp_settle_timer #(
        .CYCLES (SETTLE_CYC)
    ) u_settle_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (timer_start),
        .done      (timer_done),
        .near_done (timer_near)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and handshake outputs
    always_comb begin
        state_d     = state_q;
        feat_ready  = 1'b0;
        beat_acc    = 1'b0;
        timer_start = 1'b0;
        case (state_q)
            LOAD: begin
                feat_ready = 1'b1;
                if (feat_valid) begin
                    beat_acc = 1'b1;
                    if (is_last_slot && feat_last) begin
                        state_d     = SETTLE;
                        timer_start = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (timer_done) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Beat capture; slots of a discarded frame are intentionally left as written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            inp_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_bad;
            if (beat_acc) begin
                for (int i = 0; i < int'(N_FEAT); i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        inp_q[i*FEAT_W +: FEAT_W] <= feat_data;
                    end
                end
                // Count restarts after a good frame end or any framing error.
                if (feat_last || is_last_slot) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Result capture on the final settle cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_class_q <= '0;
        end else if (state_q == SETTLE && timer_done) begin
            res_class_q <= clf_out;
        end
    end

`ifdef MLP_SEQ_STABLE_EN
    logic [CLS_W-1:0] early_q;
    logic             res_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            early_q   <= '0;
            res_err_q <= 1'b0;
        end else begin
            if (state_q == SETTLE && timer_near) begin
                early_q <= clf_out;
            end
            if (state_q == SETTLE && timer_done) begin
                res_err_q <= (early_q != clf_out);
            end else if (state_q == HOLD && res_ready) begin
                res_err_q <= 1'b0;
            end
        end
    end

    assign res_err = res_err_q;
`else
    logic unused_near;
    assign unused_near = timer_near;
    assign res_err     = 1'b0;
`endif

    assign clf_inp   = inp_q;
    assign res_valid = (state_q == HOLD);
    assign res_class = res_class_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == SETTLE) || (state_q == HOLD);

endmodule

// File: tb/tb_mlp_frame_sequencer.sv
// Self-checking bench for mlp_frame_sequencer: expected results are queued when a
// frame is driven and compared when the sequencer raises res_valid.
module tb_mlp_frame_sequencer;
    import mlp_seq_pkg::*;

    localparam int SETTLE = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             feat_valid;
    logic [FEAT_W-1:0] feat_data;
    logic             feat_last;
    logic             feat_ready;
    logic [INP_W-1:0] clf_inp;
    logic [CLS_W-1:0] clf_out;
    logic             res_valid;
    logic [CLS_W-1:0] res_class;
    logic             res_ready;
    logic             res_err;
    logic             frame_err;
    logic             busy;

    mlp_frame_sequencer #(
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .feat_valid (feat_valid),
        .feat_data  (feat_data),
        .feat_last  (feat_last),
        .feat_ready (feat_ready),
        .clf_inp    (clf_inp),
        .clf_out    (clf_out),
        .res_valid  (res_valid),
        .res_class  (res_class),
        .res_ready  (res_ready),
        .res_err    (res_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CLS_W-1:0] cls;
        logic             err;
        logic [INP_W-1:0] inp;
        int               due;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [INP_W-1:0] model_inp = '0;
    int               last_acc  = 0;
    bit               res_seen  = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Result monitor: compare each new result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n || !res_valid) begin
            res_seen = 0;
        end else if (!res_seen) begin
            res_seen = 1;
            if (sb.size() == 0) begin
                check_eq("unexpected_result", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("res_class", res_class, mon_e.cls);
                check_eq("res_err", res_err, mon_e.err);
                check_eq("clf_inp", clf_inp, mon_e.inp);
                check_eq("latency", cyc, mon_e.due);
            end
        end
    end

    task automatic send_beat(input int k, input logic [FEAT_W-1:0] d, input logic last);
        int waited = 0;
        feat_valid = 1'b1;
        feat_data  = d;
        feat_last  = last;
        forever begin
            @(negedge clk);
            if (feat_ready) break;
            waited++;
            if (waited > 50) begin
                check_eq("beat_accept_timeout", 0, 1);
                break;
            end
        end
        last_acc = cyc;
        model_inp[k*FEAT_W +: FEAT_W] = d;
        @(posedge clk);
        #1;
        feat_valid = 1'b0;
        feat_last  = 1'b0;
    endtask

    // last_at < 0 means no beat carries feat_last.
    task automatic send_frame(input int n_beats, input int last_at, input bit ramp, input bit gaps);
        logic [FEAT_W-1:0] d;
        for (int k = 0; k < n_beats; k++) begin
            d = ramp ? FEAT_W'(k % 16) : FEAT_W'($urandom_range(0, 15));
            send_beat(k, d, k == last_at);
            if (gaps) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic expect_result(input logic [CLS_W-1:0] cls, input logic err,
                                 input logic [INP_W-1:0] inp);
        exp_t e;
        e.cls = cls;
        e.err = err;
        e.inp = inp;
        e.due = last_acc + SETTLE + 1;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || res_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check_eq("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        feat_valid = 1'b0;
        feat_data  = '0;
        feat_last  = 1'b0;
        clf_out    = 2'b10;
        res_ready  = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_clf_inp", clf_inp, 0);
        check_eq("rst_res_class", res_class, 0);
        check_eq("rst_res_err", res_err, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_feat_ready", feat_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: ramp frame, fixed class 2'b10
        clf_out = 2'b10;
        send_frame(21, 20, 1, 0);
        expect_result(2'b10, 1'b0, 84'h4_3210_FEDC_BA98_7654_3210);
        @(negedge clk);
        check_eq("settle_busy", busy, 1);
        check_eq("settle_feat_ready", feat_ready, 0);
        drain();

        // 2a: feat_last on beat 7
        send_frame(8, 7, 0, 0);
        @(negedge clk);
        check_eq("early_last_frame_err", frame_err, 1);
        check_eq("early_last_ready", feat_ready, 1);
        @(negedge clk);
        check_eq("early_last_pulse_end", frame_err, 0);
        check_eq("partial_slots_kept", clf_inp, model_inp);
        @(posedge clk);
        #1;
        // 2b: no feat_last on beat 20
        send_frame(21, -1, 0, 0);
        @(negedge clk);
        check_eq("missing_last_frame_err", frame_err, 1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        check_eq("bad_frame_no_result", seen, 0);
        @(posedge clk);
        #1;
        // 2c: recovery frame
        clf_out = 2'b01;
        send_frame(21, 20, 0, 0);
        expect_result(2'b01, 1'b0, model_inp);
        drain();

        // 3: consumer stalls in HOLD
        res_ready = 1'b0;
        clf_out   = 2'b11;
        send_frame(21, 20, 0, 0);
        expect_result(2'b11, 1'b0, model_inp);
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("hold_reached", res_valid, 1);
        clf_out = 2'b00;
        repeat (10) begin
            @(negedge clk);
            check_eq("hold_valid", res_valid, 1);
            check_eq("hold_class", res_class, 2'b11);
            check_eq("hold_feat_ready", feat_ready, 0);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("release_valid", res_valid, 0);
        check_eq("release_feat_ready", feat_ready, 1);
        @(posedge clk);
        #1;

        // 4: reset during SETTLE
        clf_out = 2'b10;
        send_frame(21, 20, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_res_valid", res_valid, 0);
        check_eq("midrst_clf_inp", clf_inp, 0);
        check_eq("midrst_res_class", res_class, 0);
        check_eq("midrst_feat_ready", feat_ready, 1);
        model_inp = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        check_eq("midrst_no_result", seen, 0);
        @(posedge clk);
        #1;
        clf_out = 2'b01;
        send_frame(21, 20, 0, 0);
        expect_result(2'b01, 1'b0, model_inp);
        drain();

        // 6: feat_valid toggling every cycle
        clf_out = 2'b00;
        send_frame(21, 20, 0, 1);
        expect_result(2'b00, 1'b0, model_inp);
        drain();

        // 5: clf_out changes on the final settle cycle
        clf_out = 2'b01;
        send_frame(21, 20, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        clf_out = 2'b00;
`ifdef MLP_SEQ_STABLE_EN
        expect_result(2'b00, 1'b1, model_inp);
`else
        expect_result(2'b00, 1'b0, model_inp);
`endif
        drain();
        check_eq("err_cleared", res_err, 0);
        clf_out = 2'b10;
        send_frame(21, 20, 0, 0);
        expect_result(2'b10, 1'b0, model_inp);
        drain();

        check_eq("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
